pkty_mlink_decode: RTL and testbench

Multi-link successor to the single-link packet-type decoder in the baseband TX path. Per-link transport mode (BR/EDR, SCO/eSCO/ACL) is held as parameterised vectors, and the selected link's `pk_type` is decoded into payload-length and encoder-control attributes. Those attributes are latched on the first TX slot. A slot-occupancy FSM then tracks multi-slot packets, with abort and collision detection. Downstream FEC, CRC and modulator control read the latched `_f` outputs.

---
 rtl/pkty_pkg.sv | 41 ++++
 rtl/pkty_mlink_decode_if.sv | 54 +++++
 rtl/pkty_attr_dec.sv | 144 ++++++++++++++
 rtl/pkty_mlink_decode.sv | 113 +++++++++++
 tb/tb_pkty_mlink_decode.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pkty_pkg.sv
// Shared packet-type codes, slot counts and decoded-attribute bundle
// for the multi-link packet-type decoder.
package pkty_pkg;

    localparam logic [3:0] PKTY_NULL = 4'h0;
    localparam logic [3:0] PKTY_POLL = 4'h1;
    localparam logic [3:0] PKTY_FHS  = 4'h2;
    localparam logic [3:0] PKTY_DM1  = 4'h3;
    localparam logic [3:0] PKTY_DH1  = 4'h4;
    localparam logic [3:0] PKTY_HV1  = 4'h5;
    localparam logic [3:0] PKTY_HV2  = 4'h6;
    localparam logic [3:0] PKTY_HV3  = 4'h7;
    localparam logic [3:0] PKTY_DV   = 4'h8;
    localparam logic [3:0] PKTY_AUX1 = 4'h9;
    localparam logic [3:0] PKTY_DM3  = 4'hA;
    localparam logic [3:0] PKTY_DH3  = 4'hB;
    localparam logic [3:0] PKTY_EV4  = 4'hC;
    localparam logic [3:0] PKTY_EV5  = 4'hD;
    localparam logic [3:0] PKTY_DM5  = 4'hE;
    localparam logic [3:0] PKTY_DH5  = 4'hF;

    localparam logic [2:0] SLOTS_1 = 3'd1;
    localparam logic [2:0] SLOTS_3 = 3'd3;
    localparam logic [2:0] SLOTS_5 = 3'd5;

    // Payload bit length width; covers byte lengths up to 10 bits
    localparam int PYLEN_W = 14;

    typedef struct packed {
        logic [PYLEN_W-1:0] pylen;
        logic [2:0]         slots;
        logic               hdr;
        logic               fec31;
        logic               fec32;
        logic               crc;
        logic               br;
        logic               dpsk;
        logic               brss;
    } pkty_attr_t;

endpackage

// File: rtl/pkty_mlink_decode_if.sv
// Control/status bundle between the TX scheduler and the packet-type
// decoder; master drives the request side, slave returns latched state.
interface pkty_mlink_decode_if #(
    parameter int NLINK = 4,
    parameter int LENW  = 10,
    parameter int LW    = $clog2(NLINK)
);
    logic [LW-1:0]     link_sel;
    logic [NLINK-1:0]  lt_is_BRmode;
    logic [NLINK-1:0]  lt_is_SCO;
    logic [NLINK-1:0]  lt_is_eSCO;
    logic [3:0]        pk_type;
    logic [LENW-1:0]   regi_payloadlen;
    logic              pk_encode_1stslot;
    logic              tslot_p;
    logic              abort;

    logic [LENW+3:0]   pylenbit_f;
    logic [2:0]        occpuy_slots_f;
    logic              fec31encode_f;
    logic              fec32encode_f;
    logic              crcencode_f;
    logic              packet_BRmode_f;
    logic              packet_DPSK_f;
    logic              BRss_f;
    logic              existpyheader_f;
    logic [LW-1:0]     link_f;
    logic              illegal_f;
    logic              tx_busy;
    logic [2:0]        slot_idx;
    logic              done_p;
    logic              collide_p;

    modport master (
        output link_sel, lt_is_BRmode, lt_is_SCO, lt_is_eSCO,
        output pk_type, regi_payloadlen, pk_encode_1stslot,
        output tslot_p, abort,
        input  pylenbit_f, occpuy_slots_f, fec31encode_f,
        input  fec32encode_f, crcencode_f, packet_BRmode_f,
        input  packet_DPSK_f, BRss_f, existpyheader_f, link_f,
        input  illegal_f, tx_busy, slot_idx, done_p, collide_p
    );

    modport slave (
        input  link_sel, lt_is_BRmode, lt_is_SCO, lt_is_eSCO,
        input  pk_type, regi_payloadlen, pk_encode_1stslot,
        input  tslot_p, abort,
        output pylenbit_f, occpuy_slots_f, fec31encode_f,
        output fec32encode_f, crcencode_f, packet_BRmode_f,
        output packet_DPSK_f, BRss_f, existpyheader_f, link_f,
        output illegal_f, tx_busy, slot_idx, done_p, collide_p
    );

endinterface

// File: rtl/pkty_attr_dec.sv
// Combinational packet-type decode into payload length and encoder
// controls. EDR support is compiled in with PKTY_EDR_EN.
module pkty_attr_dec
    import pkty_pkg::*;
#(
    parameter int LENW = 10
) (
    input  logic [3:0]      pk_type,
    input  logic [LENW-1:0] len,
    input  logic            is_br,
    input  logic            is_sco,
    input  logic            is_esco,
    output pkty_attr_t      attr,
    output logic            illegal
);

    logic               is_acl;
    logic [PYLEN_W-1:0] len_b;
    logic [PYLEN_W-1:0] len_b1;

    assign is_acl = !is_sco && !is_esco;
    assign len_b  = PYLEN_W'(len) << 3;
    assign len_b1 = (PYLEN_W'(len) + PYLEN_W'(1)) << 3;

    // Attribute table: defaults first, then per-type overrides
    always_comb begin
        attr       = '0;
        attr.hdr   = 1'b1;
        attr.fec32 = 1'b1;
        attr.crc   = 1'b1;
        attr.br    = 1'b1;
        attr.dpsk  = 1'b1;
        attr.slots = SLOTS_1;
        attr.pylen = is_acl ? len_b1 : len_b;
        unique case (pk_type)
            PKTY_NULL, PKTY_POLL: begin
                attr.pylen = '0;
                attr.hdr   = 1'b0;
            end
            PKTY_FHS: begin
                attr.pylen = PYLEN_W'(144);
                attr.hdr   = 1'b0;
            end
            PKTY_DM1: ;
            PKTY_DH1: begin
                attr.fec32 = 1'b0;
                attr.br    = is_br;
            end
            PKTY_HV1: begin
                attr.pylen = PYLEN_W'(80);
                attr.fec31 = 1'b1;
                attr.crc   = 1'b0;
                attr.hdr   = 1'b0;
            end
            PKTY_HV2: begin
                attr.hdr = 1'b0;
                if (is_esco) begin
                    attr.br    = 1'b0;
                    attr.fec32 = 1'b0;
                end else begin
                    attr.pylen = PYLEN_W'(160);
                    attr.crc   = 1'b0;
                end
            end
            PKTY_HV3: begin
                attr.hdr = 1'b0;
                if (is_esco && is_br) begin
                    attr.fec32 = 1'b0;
                end else if (is_esco) begin
                    attr.crc  = 1'b0;
                    attr.br   = 1'b0;
                    attr.dpsk = 1'b0;
                end else begin
                    attr.fec32 = 1'b0;
                    attr.crc   = 1'b0;
                    attr.pylen = PYLEN_W'(240);
                end
            end
            PKTY_DV: begin
                if (is_sco) begin
                    attr.pylen = PYLEN_W'(80) + len_b1;
                end else begin
                    attr.br    = 1'b0;
                    attr.dpsk  = 1'b0;
                    attr.fec32 = 1'b0;
                end
            end
            PKTY_AUX1: attr.crc = 1'b0;
            PKTY_DM3: begin
                attr.slots = SLOTS_3;
                attr.br    = is_br;
            end
            PKTY_DH3: begin
                attr.slots = SLOTS_3;
                attr.br    = is_br;
                attr.dpsk  = is_br;
            end
            PKTY_EV4: begin
                attr.hdr   = 1'b0;
                attr.slots = SLOTS_3;
                attr.br    = is_br;
            end
            PKTY_EV5: begin
                attr.hdr   = 1'b0;
                attr.slots = SLOTS_3;
                attr.br    = is_br;
                attr.dpsk  = is_br;
            end
            PKTY_DM5: begin
                attr.slots = SLOTS_5;
                attr.br    = is_br;
            end
            PKTY_DH5: begin
                attr.slots = SLOTS_5;
                attr.br    = is_br;
                attr.dpsk  = is_br;
            end
        endcase
`ifndef PKTY_EDR_EN
        attr.br   = 1'b1;
        attr.dpsk = 1'b1;
`endif
        attr.brss = attr.br && (attr.slots == SLOTS_1);
    end

    // Type/transport legality; eSCO wins if both mode flags are set
    always_comb begin
        illegal = 1'b0;
        if (is_esco) begin
            illegal = !(pk_type inside {PKTY_NULL, PKTY_POLL,
                                        PKTY_HV2, PKTY_HV3,
                                        PKTY_EV4, PKTY_EV5});
        end else if (is_sco) begin
            illegal = (pk_type >= PKTY_AUX1);
        end else begin
            illegal = pk_type inside {PKTY_HV1, PKTY_HV2, PKTY_HV3};
`ifndef PKTY_EDR_EN
            if (pk_type == PKTY_DV)
                illegal = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/pkty_mlink_decode.sv
// Multi-link packet-type decoder: link mux, first-slot latch and
// slot-occupancy FSM. EDR support is compiled in with PKTY_EDR_EN.
module pkty_mlink_decode
    import pkty_pkg::*;
#(
    parameter int NLINK = 4,
    parameter int LENW  = 10,
    parameter int LW    = $clog2(NLINK)
) (
    input  logic clk_6M,
    input  logic rst,
    pkty_mlink_decode_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    pkty_attr_t attr;
    logic       illegal;
    logic       is_br;
    logic       is_sco;
    logic       is_esco;

    // Transport mode of the link being encoded
    always_comb begin
        is_sco  = bus.lt_is_SCO[bus.link_sel];
        is_esco = bus.lt_is_eSCO[bus.link_sel];
`ifdef PKTY_EDR_EN
        is_br   = bus.lt_is_BRmode[bus.link_sel];
`else
        // BR-only build: mode vector stays wired but reads as BR
        is_br   = bus.lt_is_BRmode[bus.link_sel] | 1'b1;
`endif
    end

    pkty_attr_dec #(
        .LENW (LENW)
    ) u_dec (
        .pk_type (bus.pk_type),
        .len     (bus.regi_payloadlen),
        .is_br   (is_br),
        .is_sco  (is_sco),
        .is_esco (is_esco),
        .attr    (attr),
        .illegal (illegal)
    );

    // First-slot latch and slot-occupancy FSM with registered outputs
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            bus.pylenbit_f      <= '0;
            bus.occpuy_slots_f  <= '0;
            bus.fec31encode_f   <= 1'b0;
            bus.fec32encode_f   <= 1'b0;
            bus.crcencode_f     <= 1'b0;
            bus.packet_BRmode_f <= 1'b0;
            bus.packet_DPSK_f   <= 1'b0;
            bus.BRss_f          <= 1'b0;
            bus.existpyheader_f <= 1'b0;
            bus.link_f          <= '0;
            bus.illegal_f       <= 1'b0;
            bus.tx_busy         <= 1'b0;
            bus.slot_idx        <= '0;
            bus.done_p          <= 1'b0;
            bus.collide_p       <= 1'b0;
        end else begin
            bus.done_p    <= 1'b0;
            bus.collide_p <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.pk_encode_1stslot) begin
                        bus.pylenbit_f      <= (LENW+4)'(attr.pylen);
                        bus.occpuy_slots_f  <= attr.slots;
                        bus.fec31encode_f   <= attr.fec31;
                        bus.fec32encode_f   <= attr.fec32;
                        bus.crcencode_f     <= attr.crc;
                        bus.packet_BRmode_f <= attr.br;
                        bus.packet_DPSK_f   <= attr.dpsk;
                        bus.BRss_f          <= attr.brss;
                        bus.existpyheader_f <= attr.hdr;
                        bus.link_f          <= bus.link_sel;
                        bus.illegal_f       <= illegal;
                        if (!illegal) begin
                            state        <= BUSY;
                            bus.tx_busy  <= 1'b1;
                            bus.slot_idx <= 3'd1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.pk_encode_1stslot)
                        bus.collide_p <= 1'b1;
                    if (bus.abort) begin
                        state        <= IDLE;
                        bus.tx_busy  <= 1'b0;
                        bus.slot_idx <= '0;
                    end else if (bus.tslot_p) begin
                        if (bus.slot_idx == bus.occpuy_slots_f) begin
                            state        <= IDLE;
                            bus.tx_busy  <= 1'b0;
                            bus.slot_idx <= '0;
                            bus.done_p   <= 1'b1;
                        end else begin
                            bus.slot_idx <= bus.slot_idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkty_mlink_decode.sv
// Directed bench for pkty_mlink_decode: decode table plus multi-slot,
// abort, collision and reset sequences.
module tb_pkty_mlink_decode;

    logic clk_6M = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_6M = ~clk_6M;

    pkty_mlink_decode_if #(.NLINK(4), .LENW(10), .LW(2)) bus();

    pkty_mlink_decode #(
        .NLINK (4),
        .LENW  (10),
        .LW    (2)
    ) dut (
        .clk_6M (clk_6M),
        .rst    (rst),
        .bus    (bus)
    );

    // {fec31, fec32, crc, br, dpsk, brss, hdr}
    typedef struct {
        logic [1:0]  link;
        logic [3:0]  typ;
        logic [9:0]  len;
        logic [13:0] pylen;
        logic [2:0]  slots;
        logic [6:0]  flags;
        logic        ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mk(int link, int typ, int len, int pylen,
                                int slots, logic [6:0] flags, int ill);
        vec_t v;
        v.link  = 2'(link);
        v.typ   = 4'(typ);
        v.len   = 10'(len);
        v.pylen = 14'(pylen);
        v.slots = 3'(slots);
        v.flags = flags;
        v.ill   = 1'(ill);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_6M);
        #1;
    endtask

    function automatic logic [6:0] flags_now();
        return {bus.fec31encode_f, bus.fec32encode_f, bus.crcencode_f,
                bus.packet_BRmode_f, bus.packet_DPSK_f, bus.BRss_f,
                bus.existpyheader_f};
    endfunction

    task automatic strobe(input int link, input int typ, input int len,
                          input logic tslot);
        bus.link_sel          = 2'(link);
        bus.pk_type           = 4'(typ);
        bus.regi_payloadlen   = 10'(len);
        bus.pk_encode_1stslot = 1'b1;
        bus.tslot_p           = tslot;
        step();
        bus.pk_encode_1stslot = 1'b0;
        bus.tslot_p           = 1'b0;
    endtask

    task automatic tslot();
        bus.tslot_p = 1'b1;
        step();
        bus.tslot_p = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    function automatic logic any_out();
        return |{bus.pylenbit_f, bus.occpuy_slots_f, flags_now(),
                 bus.link_f, bus.illegal_f, bus.tx_busy, bus.slot_idx,
                 bus.done_p, bus.collide_p};
    endfunction

    initial begin
        vt[0]  = mk(2, 'hF, 339, 2720, 5, 7'b0111101, 0);
`ifdef PKTY_EDR_EN
        vt[1]  = mk(1, 'h7, 90, 720, 1, 7'b0100000, 0);
        vt[2]  = mk(0, 'h4, 20, 160, 1, 7'b0010101, 1);
        vt[10] = mk(2, 'h8, 4, 40, 1, 7'b0010001, 0);
        vt[11] = mk(0, 'hC, 50, 400, 3, 7'b0110100, 0);
        vt[18] = mk(0, 'hE, 2, 16, 5, 7'b0110101, 1);
`else
        vt[1]  = mk(1, 'h7, 90, 720, 1, 7'b0011110, 0);
        vt[2]  = mk(0, 'h4, 20, 160, 1, 7'b0011111, 1);
        vt[10] = mk(2, 'h8, 4, 40, 1, 7'b0011111, 1);
        vt[11] = mk(0, 'hC, 50, 400, 3, 7'b0111100, 0);
        vt[18] = mk(0, 'hE, 2, 16, 5, 7'b0111101, 1);
`endif
        vt[3]  = mk(3, 'h8, 9, 160, 1, 7'b0111111, 0);
        vt[4]  = mk(2, 'h3, 17, 144, 1, 7'b0111111, 0);
        vt[5]  = mk(2, 'h5, 12, 80, 1, 7'b1101110, 1);
        vt[6]  = mk(3, 'h5, 30, 80, 1, 7'b1101110, 0);
        vt[7]  = mk(3, 'h6, 30, 160, 1, 7'b0101110, 0);
        vt[8]  = mk(3, 'h7, 30, 240, 1, 7'b0001110, 0);
        vt[9]  = mk(3, 'h9, 30, 240, 1, 7'b0101111, 1);
        vt[12] = mk(2, 'h0, 5, 0, 1, 7'b0111110, 0);
        vt[13] = mk(2, 'h2, 5, 144, 1, 7'b0111110, 0);
        vt[14] = mk(2, 'hB, 0, 8, 3, 7'b0111101, 0);
        vt[15] = mk(2, 'h9, 1, 16, 1, 7'b0101111, 0);
        vt[16] = mk(3, 'h8, 1023, 8272, 1, 7'b0111111, 0);
        vt[17] = mk(2, 'h6, 7, 160, 1, 7'b0101110, 1);

        bus.link_sel          = '0;
        bus.lt_is_BRmode      = 4'b0100;
        bus.lt_is_SCO         = 4'b1000;
        bus.lt_is_eSCO        = 4'b0011;
        bus.pk_type           = '0;
        bus.regi_payloadlen   = '0;
        bus.pk_encode_1stslot = 1'b0;
        bus.tslot_p           = 1'b0;
        bus.abort             = 1'b0;

        #12;
        chk("reset_outputs_zero", 32'(any_out()), 0);
        rst = 1'b0;
        step();

        // Five-slot packet walks through every slot
        strobe(2, 'hF, 339, 1'b0);
        chk("dh5_pylen", 32'(bus.pylenbit_f), 2720);
        chk("dh5_slots", 32'(bus.occpuy_slots_f), 5);
        chk("dh5_slot1", 32'(bus.slot_idx), 1);
        for (int s = 2; s <= 5; s++) begin
            tslot();
            chk("dh5_slot_step", 32'(bus.slot_idx), 32'(s));
            chk("dh5_no_done", 32'(bus.done_p), 0);
        end
        tslot();
        chk("dh5_done", 32'(bus.done_p), 1);
        chk("dh5_idle", 32'(bus.tx_busy), 0);
        chk("dh5_slot0", 32'(bus.slot_idx), 0);
        step();
        chk("dh5_done_once", 32'(bus.done_p), 0);

        // Decode table
        for (int i = 0; i < NV; i++) begin
            strobe(int'(vt[i].link), int'(vt[i].typ), int'(vt[i].len),
                   1'b0);
            chk($sformatf("v%0d_pylen", i), 32'(bus.pylenbit_f),
                32'(vt[i].pylen));
            chk($sformatf("v%0d_slots", i), 32'(bus.occpuy_slots_f),
                32'(vt[i].slots));
            chk($sformatf("v%0d_flags", i), 32'(flags_now()),
                32'(vt[i].flags));
            chk($sformatf("v%0d_link", i), 32'(bus.link_f),
                32'(vt[i].link));
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_f),
                32'(vt[i].ill));
            chk($sformatf("v%0d_busy", i), 32'(bus.tx_busy),
                32'(!vt[i].ill));
            chk($sformatf("v%0d_slot", i), 32'(bus.slot_idx),
                vt[i].ill ? 0 : 1);
            do_abort();
            chk($sformatf("v%0d_idle", i), 32'(bus.tx_busy), 0);
            chk($sformatf("v%0d_no_done", i), 32'(bus.done_p), 0);
        end

        // Abort mid-packet and collision while busy
        strobe(2, 'hB, 49, 1'b0);
        tslot();
        chk("ab_slot2", 32'(bus.slot_idx), 2);
        strobe(2, 'h3, 0, 1'b0);
        chk("col_pulse", 32'(bus.collide_p), 1);
        chk("col_pylen_kept", 32'(bus.pylenbit_f), 400);
        chk("col_slots_kept", 32'(bus.occpuy_slots_f), 3);
        chk("col_slot_kept", 32'(bus.slot_idx), 2);
        step();
        chk("col_once", 32'(bus.collide_p), 0);
        do_abort();
        chk("ab_idle", 32'(bus.tx_busy), 0);
        chk("ab_slot0", 32'(bus.slot_idx), 0);
        chk("ab_no_done", 32'(bus.done_p), 0);
        step();
        chk("ab_no_done_late", 32'(bus.done_p), 0);

        // Strobe with tslot in idle, then strobe with final tslot
        strobe(2, 'h3, 1, 1'b1);
        chk("st_ts_slot1", 32'(bus.slot_idx), 1);
        chk("st_ts_busy", 32'(bus.tx_busy), 1);
        strobe(2, 'hF, 1, 1'b1);
        chk("fin_col_done", 32'(bus.done_p), 1);
        chk("fin_col_coll", 32'(bus.collide_p), 1);
        chk("fin_col_idle", 32'(bus.tx_busy), 0);
        chk("fin_col_kept", 32'(bus.occpuy_slots_f), 1);
        do_abort();
        chk("idle_abort_noop", 32'(bus.tx_busy), 0);
        chk("idle_abort_done", 32'(bus.done_p), 0);

        // Asynchronous reset mid-packet
        strobe(3, 'h8, 9, 1'b0);
        chk("dv_pylen", 32'(bus.pylenbit_f), 160);
        chk("dv_busy", 32'(bus.tx_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_zero", 32'(any_out()), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_zero", 32'(any_out()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
